// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words and queues them in a small FIFO.
// Each word leaves on a valid/ready stream together with its running byte address.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               fmt,
  input  logic [5:0]               opcode,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [5:0]               funct,
  input  logic [15:0]              imm16,
  input  logic [25:0]              imm26,
  input  logic [31:0]              raw,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [31:0]   addr;
  logic [31:0]   enc_word;
  logic          push;
  logic          pop;

  always_comb begin
    enc_word = raw;
    case (fmt)
      2'd0:    enc_word = {opcode, rs, rt, rd, shamt, funct};
      2'd1:    enc_word = {opcode, rs, rt, imm16};
      2'd2:    enc_word = {opcode, imm26};
      default: enc_word = raw;
    endcase
  end

  // Handshake: a transfer happens on an edge where valid && ready; valid never
  // waits on ready, and in_ready depends only on the registered occupancy.
  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
  assign out_addr  = addr;
  assign count     = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      addr   <= BASE_ADDR;
    end else if (restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      addr   <= BASE_ADDR;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        addr   <= addr + 32'd4;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: a slot is only visible once it has been written.
  always_ff @(posedge clk) begin
    if (push && !restart) mem[wr_ptr] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a queue-based reference model predicts every output,
// with a second instance built at a high base address to exercise address wrap.
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] WBASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] raw;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_addr;
  logic [2:0]  count;
  logic        w_in_ready, w_out_valid;
  logic [31:0] w_out_instr, w_out_addr;
  logic [2:0]  w_count;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr, exp_waddr;
  int          n_checks, n_errors;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .imm26(imm26), .raw(raw), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count)
  );

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(WBASE)) u_wrap (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .imm26(imm26), .raw(raw), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr), .count(w_count)
  );

  // Field packing from the instruction format definitions, by shift and OR.
  function automatic logic [31:0] enc_model(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] r);
    case (f)
      2'd0: return (32'(op) << 26) | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11)
                   | (32'(sh) << 6) | 32'(fn);
      2'd1: return (32'(op) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(i16);
      2'd2: return (32'(op) << 26) | 32'(i26);
      default: return r;
    endcase
  endfunction

  task automatic rand_bundle();
    fmt = 2'($urandom_range(0, 3)); opcode = 6'($urandom); rs = 5'($urandom);
    rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
    imm16 = 16'($urandom); imm26 = 26'($urandom); raw = $urandom;
  endtask

  function automatic logic [31:0] cur_word();
    return enc_model(fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26, raw);
  endfunction

  // One clock: predict the transfer from the inputs presented, then advance the model.
  task automatic cycle();
    bit acc, deq;
    logic [31:0] w;
    acc = in_valid && (exp_q.size() != DEPTH);
    deq = (exp_q.size() != 0) && out_ready;
    w   = cur_word();
    @(posedge clk);
    if (restart) begin
      exp_q.delete(); exp_addr = BASE; exp_waddr = WBASE;
    end else begin
      if (deq) begin void'(exp_q.pop_front()); exp_addr += 32'd4; exp_waddr += 32'd4; end
      if (acc) exp_q.push_back(w);
    end
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1; in_valid = 1'b0; cycle(); restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rand_bundle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete(); exp_addr = BASE; exp_waddr = WBASE;
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_instr !== 32'h0) begin n_errors++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
    n_checks++; if (out_addr !== BASE) begin n_errors++; $display("FAIL reset_out_addr: got %h expected %h", out_addr, BASE); end
    n_checks++; if (w_out_addr !== WBASE) begin n_errors++; $display("FAIL reset_wrap_addr: got %h expected %h", w_out_addr, WBASE); end
  endtask

  task automatic test_encode();
    logic [31:0] want_i [3] = '{32'h00221821, 32'h34011234, 32'h08000c00};
    logic [31:0] want_a [3] = '{32'h00003000, 32'h00003004, 32'h00003008};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_bundle();
      case (i)
        0: begin fmt = 2'd0; opcode = 6'h00; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h21; end
        1: begin fmt = 2'd1; opcode = 6'h0d; rs = 5'd0; rt = 5'd1; imm16 = 16'h1234; end
        default: begin fmt = 2'd2; opcode = 6'h02; imm26 = 26'h0000c00; end
      endcase
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_checks++; if (out_instr !== want_i[i]) begin n_errors++; $display("FAIL enc_instr[%0d]: got %h expected %h", i, out_instr, want_i[i]); end
      n_checks++; if (out_addr !== want_a[i]) begin n_errors++; $display("FAIL enc_addr[%0d]: got %h expected %h", i, out_addr, want_a[i]); end
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL enc_valid[%0d]: got %b expected 1", i, out_valid); end
    end
    cycle();
    n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin n_errors++; $display("FAIL enc_empty: got valid %b instr %h expected 0 0", out_valid, out_instr); end
    n_checks++; if (out_addr !== 32'h0000300C) begin n_errors++; $display("FAIL enc_next_addr: got %h expected 0000300c", out_addr); end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [5];
    do_restart();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_bundle(); words[i] = cur_word(); in_valid = 1'b1;
      cycle();
      n_checks++; if (count !== 3'((i < 4) ? i + 1 : 4)) begin n_errors++; $display("FAIL bp_count[%0d]: got %0d expected %0d", i, count, (i < 4) ? i + 1 : 4); end
    end
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_instr !== words[i]) begin n_errors++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, out_instr, words[i]); end
      n_checks++; if (out_addr !== BASE + 32'(4 * i)) begin n_errors++; $display("FAIL bp_addr[%0d]: got %h expected %h", i, out_addr, BASE + 32'(4 * i)); end
      cycle();
      if (i == 0) begin
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_in_ready_return: got %b expected 1", in_ready); end
      end
    end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL bp_drained: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    do_restart();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin rand_bundle(); cycle(); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_bundle();
      cycle();
      n_checks++; if (count !== 3'd2) begin n_errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
      n_checks++; if (out_addr !== BASE + 32'(4 * (i + 1))) begin n_errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, out_addr, BASE + 32'(4 * (i + 1))); end
      n_checks++; if (out_instr !== exp_q[0]) begin n_errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, out_instr, exp_q[0]); end
    end
    in_valid = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_restart();
    do_restart();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin rand_bundle(); cycle(); end
    n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL rs_pre_count: got %0d expected 3", count); end
    rand_bundle(); restart = 1'b1; out_ready = 1'b1;
    cycle();
    restart = 1'b0; in_valid = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL rs_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rs_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_addr !== 32'h0000_3000) begin n_errors++; $display("FAIL rs_addr: got %h expected 00003000", out_addr); end
    n_checks++; if (w_out_addr !== WBASE) begin n_errors++; $display("FAIL rs_wrap_addr: got %h expected %h", w_out_addr, WBASE); end
  endtask

  task automatic test_reset_mid();
    do_restart();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin rand_bundle(); cycle(); end
    in_valid = 1'b0; out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    exp_q.delete(); exp_addr = BASE; exp_waddr = WBASE;
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL rm_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL rm_flags: got valid %b ready %b expected 0 1", out_valid, in_ready); end
    n_checks++; if (out_instr !== 32'h0) begin n_errors++; $display("FAIL rm_instr: got %h expected 0", out_instr); end
    n_checks++; if (out_addr !== BASE) begin n_errors++; $display("FAIL rm_addr: got %h expected %h", out_addr, BASE); end
    #1 reset = 1'b1;
    out_ready = 1'b0; rand_bundle(); fmt = 2'd3; raw = 32'hDEADBEEF; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_instr !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rm_first_instr: got %h expected deadbeef", out_instr); end
    n_checks++; if (out_addr !== 32'h0000_3000) begin n_errors++; $display("FAIL rm_first_addr: got %h expected 00003000", out_addr); end
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] want_a [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_restart();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_bundle(); in_valid = 1'b1;
      cycle();
      n_checks++; if (w_out_addr !== want_a[i]) begin n_errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, w_out_addr, want_a[i]); end
      n_checks++; if (w_out_instr !== exp_q[0]) begin n_errors++; $display("FAIL wrap_instr[%0d]: got %h expected %h", i, w_out_instr, exp_q[0]); end
    end
    in_valid = 1'b0;
    cycle();
    n_checks++; if (w_out_addr !== 32'h0000_0004) begin n_errors++; $display("FAIL wrap_next: got %h expected 00000004", w_out_addr); end
  endtask

  task automatic test_random();
    logic [31:0] e_instr;
    for (int i = 0; i < 300; i++) begin
      rand_bundle();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      restart   = ($urandom_range(0, 39) == 0);
      cycle();
      restart = 1'b0;
      e_instr = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
      n_checks++; if (count !== 3'(exp_q.size())) begin n_errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, exp_q.size()); end
      n_checks++; if (out_instr !== e_instr) begin n_errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, out_instr, e_instr); end
      n_checks++; if (out_addr !== exp_addr) begin n_errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, out_addr, exp_addr); end
      n_checks++; if (w_out_addr !== exp_waddr) begin n_errors++; $display("FAIL rnd_waddr[%0d]: got %h expected %h", i, w_out_addr, exp_waddr); end
      n_checks++; if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() != DEPTH)) begin
        n_errors++; $display("FAIL rnd_flags[%0d]: got valid %b ready %b expected %b %b", i, out_valid, in_ready, exp_q.size() != 0, exp_q.size() != DEPTH);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    test_reset();
    test_encode();
    test_backpressure();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
